// File: rtl/ray_axi_pkg.sv
// ray_axi_pkg: shared AXI-Lite response codes, loader state encoding and
// register word indices of the pixel generator's parameter file.
`default_nettype none

package ray_axi_pkg;

   localparam logic [1:0] AXI_OK  = 2'b00;
   localparam logic [1:0] AXI_ERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WADDR = 3'd1,
      ST_WRESP = 3'd2,
      ST_RADDR = 3'd3,
      ST_RDATA = 3'd4,
      ST_NEXT  = 3'd5,
      ST_FIN   = 3'd6
   } loader_state_t;

   localparam int LIGHT_OBJSEL  = 0;
   localparam int CAM_POS       = 1;
   localparam int CAM_DIR       = 2;
   localparam int CAM_UP        = 3;
   localparam int CAM_RIGHT     = 4;
   localparam int FOV_SCALE     = 5;
   localparam int RESERVED_6    = 6;
   localparam int NORMAL_FACTOR = 7;

endpackage

`default_nettype wire

// File: rtl/axi_lite_param_loader.sv
// axi_lite_param_loader: AXI-Lite initiator that writes a snapshot of scene
// parameters to consecutive word addresses, optionally reading each one back.
`default_nettype none

module axi_lite_param_loader
   import ray_axi_pkg::*;
#(
   parameter int AXI_LITE_ADDR_WIDTH = 8,
   parameter int NUM_REGS            = 8,
   parameter int BASE_ADDR           = 0,
   parameter int READBACK            = 1
) (
   input  logic                             m_axi_lite_aclk,
   input  logic                             axi_resetn,
   input  logic                             start,
   input  logic [32*NUM_REGS-1:0]           reg_values,
   output logic                             busy,
   output logic                             done,
   output logic                             err,
   output logic [$clog2(NUM_REGS)-1:0]      err_index,
   output logic [AXI_LITE_ADDR_WIDTH-1:0]   m_axi_lite_awaddr,
   output logic                             m_axi_lite_awvalid,
   input  logic                             m_axi_lite_awready,
   output logic [31:0]                      m_axi_lite_wdata,
   output logic [3:0]                       m_axi_lite_wstrb,
   output logic                             m_axi_lite_wvalid,
   input  logic                             m_axi_lite_wready,
   input  logic [1:0]                       m_axi_lite_bresp,
   input  logic                             m_axi_lite_bvalid,
   output logic                             m_axi_lite_bready,
   output logic [AXI_LITE_ADDR_WIDTH-1:0]   m_axi_lite_araddr,
   output logic                             m_axi_lite_arvalid,
   input  logic                             m_axi_lite_arready,
   input  logic [31:0]                      m_axi_lite_rdata,
   input  logic [1:0]                       m_axi_lite_rresp,
   input  logic                             m_axi_lite_rvalid,
   output logic                             m_axi_lite_rready
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam longint LAST_ADDR = longint'(BASE_ADDR) + 64'd4 * longint'(NUM_REGS - 1);

   if ((NUM_REGS < 2) || (LAST_ADDR >= (64'd1 << AXI_LITE_ADDR_WIDTH))) begin : g_addr_check
      $error("axi_lite_param_loader: register window does not fit the address width");
   end

   loader_state_t state, state_n;
   logic [IDX_W-1:0] index;
   logic             aw_done, w_done;
   logic [31:0]      shadow [NUM_REGS];
   logic [AXI_LITE_ADDR_WIDTH-1:0] addr;
   logic             aw_hs, w_hs, last, rd_bad;

   // Word address wraps silently within the bus width.
   assign addr   = AXI_LITE_ADDR_WIDTH'(BASE_ADDR) + AXI_LITE_ADDR_WIDTH'({index, 2'b00});
   assign aw_hs  = m_axi_lite_awvalid && m_axi_lite_awready;
   assign w_hs   = m_axi_lite_wvalid && m_axi_lite_wready;
   assign last   = (index == IDX_W'(NUM_REGS - 1));
   assign rd_bad = (m_axi_lite_rresp != AXI_OK) || (m_axi_lite_rdata != shadow[index]);

   assign m_axi_lite_awaddr  = addr;
   assign m_axi_lite_araddr  = addr;
   assign m_axi_lite_wdata   = shadow[index];
   assign m_axi_lite_wstrb   = 4'hF;
   assign m_axi_lite_awvalid = (state == ST_WADDR) && !aw_done;
   assign m_axi_lite_wvalid  = (state == ST_WADDR) && !w_done;
   assign m_axi_lite_bready  = (state == ST_WRESP);
   assign m_axi_lite_arvalid = (state == ST_RADDR);
   assign m_axi_lite_rready  = (state == ST_RDATA);
   assign busy               = (state != ST_IDLE) && (state != ST_FIN);
   assign done               = (state == ST_FIN);

   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:  if (start) state_n = ST_WADDR;
         ST_WADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = ST_WRESP;
         ST_WRESP: begin
            if (m_axi_lite_bvalid) begin
               if (m_axi_lite_bresp != AXI_OK) state_n = ST_FIN;
               else if (READBACK != 0)         state_n = ST_RADDR;
               else                            state_n = ST_NEXT;
            end
         end
         ST_RADDR: if (m_axi_lite_arready) state_n = ST_RDATA;
         ST_RDATA: if (m_axi_lite_rvalid) state_n = rd_bad ? ST_FIN : ST_NEXT;
         ST_NEXT:  state_n = last ? ST_FIN : ST_WADDR;
         ST_FIN:   state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state     <= ST_IDLE;
         index     <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         err       <= 1'b0;
         err_index <= '0;
      end else begin
         state <= state_n;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  err   <= 1'b0;
                  index <= '0;
               end
            end
            ST_WADDR: begin
               // Per-channel flags let each valid drop on its own handshake.
               if (state_n != ST_WADDR) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end else begin
                  if (aw_hs) aw_done <= 1'b1;
                  if (w_hs)  w_done  <= 1'b1;
               end
            end
            ST_WRESP: begin
               if (m_axi_lite_bvalid && (m_axi_lite_bresp != AXI_OK)) begin
                  err       <= 1'b1;
                  err_index <= index;
               end
            end
            ST_RDATA: begin
               if (m_axi_lite_rvalid && rd_bad) begin
                  err       <= 1'b1;
                  err_index <= index;
               end
            end
            ST_NEXT: if (!last) index <= index + IDX_W'(1);
            default: ;
         endcase
      end
   end

   // Snapshot is data-only; its contents are irrelevant until the next start.
   always_ff @(posedge m_axi_lite_aclk) begin
      if ((state == ST_IDLE) && start) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow[i] <= reg_values[32*i +: 32];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_param_loader.sv
// tb_axi_lite_param_loader: scoreboard bench with a behavioural AXI-Lite
// register-file slave for axi_lite_param_loader.
`default_nettype none

module tb_axi_lite_param_loader;
   import ray_axi_pkg::*;

   localparam int NREG = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [32*NREG-1:0]  reg_values;
   logic                busy, done, err;
   logic [2:0]          err_index;
   logic [7:0]          awaddr, araddr;
   logic                awvalid, awready, wvalid, wready, bvalid, bready;
   logic                arvalid, arready, rvalid, rready;
   logic [31:0]         wdata, rdata;
   logic [3:0]          wstrb;
   logic [1:0]          bresp, rresp;

   logic [31:0] vals [NREG];

   always_comb begin
      reg_values = '0;
      for (int i = 0; i < NREG; i++) reg_values[32*i +: 32] = vals[i];
   end

   axi_lite_param_loader dut (
      .m_axi_lite_aclk   (clk),
      .axi_resetn        (rst_n),
      .start             (start),
      .reg_values        (reg_values),
      .busy              (busy),
      .done              (done),
      .err               (err),
      .err_index         (err_index),
      .m_axi_lite_awaddr (awaddr),
      .m_axi_lite_awvalid(awvalid),
      .m_axi_lite_awready(awready),
      .m_axi_lite_wdata  (wdata),
      .m_axi_lite_wstrb  (wstrb),
      .m_axi_lite_wvalid (wvalid),
      .m_axi_lite_wready (wready),
      .m_axi_lite_bresp  (bresp),
      .m_axi_lite_bvalid (bvalid),
      .m_axi_lite_bready (bready),
      .m_axi_lite_araddr (araddr),
      .m_axi_lite_arvalid(arvalid),
      .m_axi_lite_arready(arready),
      .m_axi_lite_rdata  (rdata),
      .m_axi_lite_rresp  (rresp),
      .m_axi_lite_rvalid (rvalid),
      .m_axi_lite_rready (rready)
   );

   // ---------------- behavioural slave ----------------
   int          aw_delay = 0, w_delay = 0, ar_delay = 0;
   int          err_word = -1, corrupt_word = -1;
   logic        clr_rf = 1'b0;
   int          aw_wait, w_wait, ar_wait;
   logic        aw_got, w_got;
   logic [7:0]  s_addr;
   logic [31:0] s_data;
   logic [31:0] rf [NREG];

   assign awready = (aw_wait >= aw_delay);
   assign wready  = (w_wait >= w_delay);
   assign arready = (ar_wait >= ar_delay);

   always @(posedge clk or negedge rst_n) begin : slave
      logic       ahs, whs, ah, wh;
      logic [7:0] a;
      logic [31:0] d;
      if (!rst_n) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         bvalid <= 1'b0; rvalid <= 1'b0;
         bresp <= AXI_OK; rresp <= AXI_OK; rdata <= '0;
         s_addr <= '0; s_data <= '0;
      end else begin
         ahs = awvalid && awready;
         whs = wvalid && wready;
         if (ahs) begin s_addr <= awaddr; aw_wait <= 0; end
         else if (awvalid) aw_wait <= aw_wait + 1;
         if (whs) begin s_data <= wdata; w_wait <= 0; end
         else if (wvalid) w_wait <= w_wait + 1;
         ah = aw_got || ahs;
         wh = w_got || whs;
         a  = aw_got ? s_addr : awaddr;
         d  = w_got ? s_data : wdata;
         if (bvalid && bready) bvalid <= 1'b0;
         if (ah && wh) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b1;
            if ((a >= 8'd32) || (int'(a[7:2]) == err_word)) bresp <= AXI_ERR;
            else begin bresp <= AXI_OK; rf[a[4:2]] <= d; end
         end else begin
            aw_got <= ah; w_got <= wh;
         end
         if (rvalid && rready) rvalid <= 1'b0;
         if (arvalid && arready) begin
            ar_wait <= 0;
            rvalid  <= 1'b1;
            rresp   <= (araddr >= 8'd32) ? AXI_ERR : AXI_OK;
            rdata   <= rf[araddr[4:2]] ^ ((int'(araddr[7:2]) == corrupt_word) ? 32'd1 : 32'd0);
         end else if (arvalid) ar_wait <= ar_wait + 1;
         if (clr_rf) for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
   typedef struct { logic err; logic [2:0] idx; int lat; } dn_t;
   wr_t exp_wr[$];
   dn_t exp_dn[$];

   int tests = 0, fails = 0;
   int cyc = 0, start_cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   logic m_aw = 1'b0, m_w = 1'b0;
   always @(negedge clk) begin : monitor
      dn_t e;
      if (!rst_n) begin
         m_aw = 1'b0; m_w = 1'b0;
      end else begin
         if (awvalid && awready) begin
            if (exp_wr.size() == 0) chk("unexpected_aw", {56'd0, awaddr}, 64'hFFFF);
            else chk("awaddr", {56'd0, awaddr}, {56'd0, exp_wr[0].addr});
            m_aw = 1'b1;
         end
         if (wvalid && wready) begin
            if (exp_wr.size() == 0) chk("unexpected_w", {32'd0, wdata}, 64'hFFFF_FFFF_FFFF);
            else chk("wdata", {32'd0, wdata}, {32'd0, exp_wr[0].data});
            chk("wstrb", {60'd0, wstrb}, 64'hF);
            m_w = 1'b1;
         end
         if (m_aw && m_w) begin
            if (exp_wr.size() > 0) void'(exp_wr.pop_front());
            m_aw = 1'b0; m_w = 1'b0;
         end
         if (done) begin
            if (exp_dn.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
               e = exp_dn.pop_front();
               chk("done_err", {63'd0, err}, {63'd0, e.err});
               chk("done_err_index", {61'd0, err_index}, {61'd0, e.idx});
               // Inclusive count: start cycle through done cycle.
               if (e.lat >= 0) chk("done_latency", 64'(cyc - start_cyc + 1), 64'(e.lat));
               chk("busy_at_done", {63'd0, busy}, 64'd0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_start(input int nw, input logic e, input logic [2:0] ei, input int lat);
      wr_t w;
      dn_t d;
      for (int i = 0; i < nw; i++) begin
         w.addr = 8'(4 * i);
         w.data = vals[i];
         exp_wr.push_back(w);
      end
      d.err = e; d.idx = ei; d.lat = lat;
      exp_dn.push_back(d);
      @(negedge clk);
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      chk("done_seen", {63'd0, seen}, 64'd1);
   endtask

   task automatic clear_rf();
      @(negedge clk); clr_rf = 1'b1;
      @(negedge clk); clr_rf = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic found;
      vals[0] = 32'h00030500; vals[1] = 32'h0; vals[2] = 32'h0; vals[3] = 32'h01000000;
      vals[4] = 32'hff000000; vals[5] = 32'h0; vals[6] = 32'h0; vals[7] = 32'h03000000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_outputs", {55'd0, awvalid, wvalid, bready, arvalid, rready, busy, done, err, 1'b0},
          64'd0);
      chk("reset_err_index", {61'd0, err_index}, 64'd0);

      // 1: basic write with readback, slave always ready
      clear_rf();
      do_start(8, 1'b0, 3'd0, 8*5 + 2);
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      wait_done(200);
      for (int i = 0; i < NREG; i++) chk($sformatf("t1_rf%0d", i), {32'd0, rf[i]}, {32'd0, vals[i]});

      // 2: split handshake, awready late by 3 cycles
      for (int i = 0; i < NREG; i++) vals[i] = 32'hA5000000 + 32'h01010101 * i;
      aw_delay = 3;
      do_start(8, 1'b0, 3'd0, -1);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (wvalid && wready) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("t2_w_first", {63'd0, found}, 64'd1);
      @(negedge clk);
      chk("t2_split", {62'd0, wvalid, awvalid}, 64'b01);
      wait_done(400);
      aw_delay = 0;
      chk("t2_rf0", {32'd0, rf[0]}, {32'd0, vals[0]});
      chk("t2_rf7", {32'd0, rf[7]}, {32'd0, vals[7]});

      // 3: error write response on word 5 aborts the sequence
      err_word = 5;
      do_start(6, 1'b1, 3'd5, -1);
      wait_done(400);
      err_word = -1;
      repeat (2) @(negedge clk);
      chk("t3_err_sticky", {63'd0, err}, 64'd1);

      // 4: readback mismatch on word 2; err clears on the new start
      corrupt_word = 2;
      do_start(3, 1'b1, 3'd2, -1);
      chk("t4_err_cleared", {63'd0, err}, 64'd0);
      wait_done(400);
      corrupt_word = -1;

      // 5: reset asserted while word 3 is in WADDR
      clear_rf();
      do_start(8, 1'b0, 3'd0, -1);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (awvalid && (awaddr == 8'd12)) begin found = 1'b1; break; end
      end
      chk("t5_reached_word3", {63'd0, found}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_drop", {58'd0, awvalid, wvalid, bready, arvalid, rready, busy}, 64'd0);
      exp_wr.delete();
      exp_dn.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_rf();
      do_start(8, 1'b0, 3'd0, 8*5 + 2);
      wait_done(200);
      chk("t5_rf3", {32'd0, rf[3]}, {32'd0, vals[3]});

      // 6a: start while busy and start during done are ignored (random delays)
      aw_delay = $urandom_range(0, 2);
      w_delay  = $urandom_range(0, 2);
      ar_delay = $urandom_range(0, 2);
      do_start(8, 1'b0, 3'd0, -1);
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(600);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_start_at_done_ignored", {63'd0, busy}, 64'd0);
      aw_delay = 0; w_delay = 0; ar_delay = 0;

      // 6b: start in the cycle right after done is accepted
      do_start(8, 1'b0, 3'd0, 8*5 + 2);
      wait_done(200);
      do_start(8, 1'b0, 3'd0, 8*5 + 2);
      wait_done(200);
      repeat (3) @(negedge clk);
      chk("final_wr_queue_empty", 64'(exp_wr.size()), 64'd0);
      chk("final_done_queue_empty", 64'(exp_dn.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
